// File: rtl/mem_arb_pkg.sv
// Shared types for the two-sided (instruction/data) memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  trd;
        logic        wr;
        logic [31:0] wdata;
    } slot_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  trd;
        logic        wr;
        logic [31:0] data;
    } fbuf_t;

    // Word-aligned and inside the backing store.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < (33'(words) * 33'd4));
    endfunction

endpackage

// File: rtl/mem_arb_side.sv
// One requester side: bounds check, fill-buffer hit compare, pending slot and fill buffer.
module mem_arb_side
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  trd,
    input  logic [31:0] wdata,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        segfault,
    input  logic        granted,
    input  logic        fill,
    input  logic [31:0] fill_data,
    input  logic        inval,
    input  logic [31:0] inval_addr,
    output logic        pend,
    output logic        enq,
    output logic [31:0] slot_addr,
    output logic        slot_wr,
    output logic [31:0] slot_wdata
);

    slot_t slot;
    fbuf_t fbuf;
    logic  req;
    logic  hit;

    // A request with both rd and wr set is a write, so wr alone is the tag bit.
    always_comb begin
        req      = rd | wr;
        segfault = req && !addr_ok(addr, MEM_WORDS);
        hit      = req && !segfault && fbuf.valid && (fbuf.addr == addr) &&
                   (fbuf.trd == trd) && (fbuf.wr == wr);
        miss     = req && !segfault && !hit;
        rd_data  = hit ? fbuf.data : '0;
        enq      = miss && !slot.valid && !granted;
    end

    assign pend       = slot.valid;
    assign slot_addr  = slot.addr;
    assign slot_wr    = slot.wr;
    assign slot_wdata = slot.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (fill) begin
            slot.valid <= 1'b0;
        end else if (enq) begin
            slot <= '{valid: 1'b1, addr: addr, trd: trd, wr: wr, wdata: wdata};
        end
    end

    // A fill overrides a same-cycle hit consume so the new contents survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fbuf <= '0;
        end else if (fill) begin
            fbuf <= '{valid: 1'b1, addr: slot.addr, trd: slot.trd, wr: slot.wr,
                      data: slot.wr ? slot.wdata : fill_data};
        end else if (hit || (inval && (fbuf.addr == inval_addr))) begin
            fbuf.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction and data sides.
// Optional MEM_ARB_PERF_EN adds saturating miss/conflict counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic        i_rd,
    input  logic [2:0]  i_trd,
    output logic [31:0] i_rd_data,
    output logic        i_miss,
    output logic        i_segfault,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [2:0]  d_trd,
    output logic [31:0] d_rd_data,
    output logic        d_miss,
    output logic        d_segfault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] i_miss_cnt,
    output logic [31:0] d_miss_cnt,
    output logic [31:0] conflict_cnt
`endif
);

    arb_state_t  state, nstate;
    gnt_t        last_grant;
    logic        i_pend, i_enq, i_slot_wr, i_fill, i_want;
    logic        d_pend, d_enq, d_slot_wr, d_fill, d_want;
    logic [31:0] i_slot_addr, i_slot_wdata;
    logic [31:0] d_slot_addr, d_slot_wdata;

    assign i_fill = (state == BUSY_I) && mem_ack;
    assign d_fill = (state == BUSY_D) && mem_ack;
    // Enqueues count as pending so the grant lands on the edge that loads the slot.
    assign i_want = i_pend | i_enq;
    assign d_want = d_pend | d_enq;

    mem_arb_side #(.MEM_WORDS(MEM_WORDS)) u_side_i (
        .clk        (clk),
        .rst        (rst),
        .addr       (i_addr),
        .rd         (i_rd),
        .wr         (1'b0),
        .trd        (i_trd),
        .wdata      ('0),
        .rd_data    (i_rd_data),
        .miss       (i_miss),
        .segfault   (i_segfault),
        .granted    (state == BUSY_I),
        .fill       (i_fill),
        .fill_data  (mem_rdata),
        .inval      (d_fill && d_slot_wr),
        .inval_addr (d_slot_addr),
        .pend       (i_pend),
        .enq        (i_enq),
        .slot_addr  (i_slot_addr),
        .slot_wr    (i_slot_wr),
        .slot_wdata (i_slot_wdata)
    );

    mem_arb_side #(.MEM_WORDS(MEM_WORDS)) u_side_d (
        .clk        (clk),
        .rst        (rst),
        .addr       (d_addr),
        .rd         (d_rd),
        .wr         (d_wr),
        .trd        (d_trd),
        .wdata      (d_wr_data),
        .rd_data    (d_rd_data),
        .miss       (d_miss),
        .segfault   (d_segfault),
        .granted    (state == BUSY_D),
        .fill       (d_fill),
        .fill_data  (mem_rdata),
        .inval      (1'b0),
        .inval_addr ('0),
        .pend       (d_pend),
        .enq        (d_enq),
        .slot_addr  (d_slot_addr),
        .slot_wr    (d_slot_wr),
        .slot_wdata (d_slot_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_D;
        end else begin
            state <= nstate;
            if (i_fill)
                last_grant <= GNT_I;
            else if (d_fill)
                last_grant <= GNT_D;
        end
    end

    always_comb begin
        nstate    = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (i_want && d_want)
                    nstate = (last_grant == GNT_D) ? BUSY_I : BUSY_D;
                else if (i_want)
                    nstate = BUSY_I;
                else if (d_want)
                    nstate = BUSY_D;
            end
            BUSY_I: begin
                mem_req   = 1'b1;
                mem_we    = i_slot_wr;
                mem_addr  = i_slot_addr;
                mem_wdata = i_slot_wdata;
                if (mem_ack)
                    nstate = IDLE;
            end
            BUSY_D: begin
                mem_req   = 1'b1;
                mem_we    = d_slot_wr;
                mem_addr  = d_slot_addr;
                mem_wdata = d_slot_wdata;
                if (mem_ack)
                    nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_miss_cnt   <= '0;
            d_miss_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (i_enq && (i_miss_cnt != '1))
                i_miss_cnt <= i_miss_cnt + 32'd1;
            if (d_enq && (d_miss_cnt != '1))
                d_miss_cnt <= d_miss_cnt + 32'd1;
            if ((state == IDLE) && i_want && d_want && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter against a fixed-latency memory model.
module tb_mem_arbiter;

    localparam int unsigned MW = 16384;
    localparam int          L  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr, d_addr, d_wr_data;
    logic        i_rd, d_rd, d_wr;
    logic [2:0]  i_trd, d_trd;
    logic [31:0] i_rd_data, d_rd_data;
    logic        i_miss, i_segfault, d_miss, d_segfault;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    acc_t exp_q[$];
    wr_t  wlog[$];

    logic        model_ack, stray_ack, active;
    logic [31:0] model_rdata;
    int          cnt;
    logic        req_q = 1'b0;

    assign mem_ack   = model_ack | stray_ack;
    assign mem_rdata = stray_ack ? 32'hBAD0_BAD0 : model_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_rd(i_rd), .i_trd(i_trd),
        .i_rd_data(i_rd_data), .i_miss(i_miss), .i_segfault(i_segfault),
        .d_addr(d_addr), .d_wr_data(d_wr_data), .d_rd(d_rd), .d_wr(d_wr), .d_trd(d_trd),
        .d_rd_data(d_rd_data), .d_miss(d_miss), .d_segfault(d_segfault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        return (a * 32'h9E37) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        for (int k = wlog.size() - 1; k >= 0; k--)
            if (wlog[k].a == a) return wlog[k].d;
        return pat(a);
    endfunction

    // Memory: ack L cycles after mem_req first rises.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0; cnt <= 0; model_ack <= 1'b0; model_rdata <= '0;
        end else begin
            model_ack <= 1'b0;
            if (mem_req && !mem_ack) begin
                if (!active) begin
                    active <= 1'b1; cnt <= 1;
                end else if (cnt == L - 1) begin
                    model_ack   <= 1'b1;
                    active      <= 1'b0;
                    model_rdata <= mem_we ? mem_wdata : mem_rd(mem_addr);
                    if (mem_we) wlog.push_back('{mem_addr, mem_wdata});
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    // Scoreboard: each new memory access must match the next expected one.
    always @(negedge clk) begin
        if (mem_req && !req_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: access we=%0b addr=%h, none expected", mem_we, mem_addr);
            end else begin
                acc_t e;
                e = exp_q.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL sb_access: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                end
            end
        end
        req_q = mem_req;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        i_rd = 0; i_addr = '0; i_trd = '0;
        d_rd = 0; d_wr = 0; d_addr = '0; d_wr_data = '0; d_trd = '0;
    endtask

    task automatic do_reset();
        step(); rst = 1; idle_in();
        step(); step(); rst = 0;
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] wd);
        exp_q.push_back('{we, a, wd});
    endtask

    task automatic i_xfer(input logic [31:0] a, input logic [2:0] t,
                          output logic [31:0] data, output bit ok);
        ok = 0; data = '0;
        for (int n = 0; n < 40 && !ok; n++) begin
            step(); i_rd = 1; i_addr = a; i_trd = t;
            @(negedge clk);
            if (!i_miss && !i_segfault) begin ok = 1; data = i_rd_data; end
        end
        step(); i_rd = 0;
    endtask

    task automatic d_xfer(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] wd, output logic [31:0] data, output bit ok);
        ok = 0; data = '0;
        for (int n = 0; n < 40 && !ok; n++) begin
            step(); d_rd = r; d_wr = w; d_addr = a; d_wr_data = wd; d_trd = 3'd0;
            @(negedge clk);
            if (!d_miss && !d_segfault) begin ok = 1; data = d_rd_data; end
        end
        step(); d_rd = 0; d_wr = 0;
    endtask

    task automatic test_reset();
        rst = 1; stray_ack = 0; idle_in();
        step(); step();
        @(negedge clk);
        checks++;
        if ({mem_req, i_miss, d_miss, i_segfault, d_segfault} !== 5'b0 ||
            i_rd_data !== 32'h0 || d_rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%0b im=%0b dm=%0b is=%0b ds=%0b ird=%h drd=%h, want all 0",
                     mem_req, i_miss, d_miss, i_segfault, d_segfault, i_rd_data, d_rd_data);
        end
        step(); rst = 0;
    endtask

    task automatic test_fetch();
        step(); i_rd = 1; i_addr = 32'h40; i_trd = 3'd2; push(0, 32'h40, 0);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            @(negedge clk);
            checks++;
            if (i_miss !== (k < 5) || mem_req !== (k >= 1 && k <= 4)) begin
                errors++;
                $display("FAIL fetch_c%0d: i_miss=%0b mem_req=%0b, want %0b %0b",
                         k, i_miss, mem_req, k < 5, k >= 1 && k <= 4);
            end
        end
        checks++;
        if (i_rd_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL fetch_data: got %h want deadbeef", i_rd_data);
        end
        step(); i_rd = 0;
    endtask

    task automatic test_arbitration();
        logic [31:0] dat;
        bit ok;
        logic er;
        do_reset();
        step(); i_rd = 1; i_addr = 32'h100; d_rd = 1; d_addr = 32'h200;
        push(0, 32'h100, 0); push(0, 32'h200, 0);
        @(negedge clk);
        checks++;
        if (i_miss !== 1'b1 || d_miss !== 1'b1) begin
            errors++; $display("FAIL arb_miss: im=%0b dm=%0b want 1 1", i_miss, d_miss);
        end
        for (int k = 1; k <= 10; k++) begin
            step(); if (k == 1) idle_in();
            @(negedge clk);
            er = (k >= 1 && k <= 4) || (k >= 6 && k <= 9);
            checks++;
            if (mem_req !== er || (er && mem_addr !== ((k <= 4) ? 32'h100 : 32'h200))) begin
                errors++;
                $display("FAIL arb_seq_c%0d: req=%0b addr=%h want req=%0b", k, mem_req, mem_addr, er);
            end
        end
        step(); i_rd = 1; i_addr = 32'h100; d_rd = 1; d_addr = 32'h200;
        @(negedge clk);
        checks++;
        if (i_miss !== 1'b0 || d_miss !== 1'b0 || i_rd_data !== pat(32'h100) || d_rd_data !== pat(32'h200)) begin
            errors++;
            $display("FAIL arb_hits: im=%0b dm=%0b ird=%h drd=%h want 0 0 %h %h",
                     i_miss, d_miss, i_rd_data, d_rd_data, pat(32'h100), pat(32'h200));
        end
        step(); idle_in();
        push(0, 32'h300, 0);
        i_xfer(32'h300, 3'd0, dat, ok);
        checks++;
        if (!ok || dat !== pat(32'h300)) begin
            errors++; $display("FAIL arb_lone_i: ok=%0b data=%h want %h", ok, dat, pat(32'h300));
        end
        step(); i_rd = 1; i_addr = 32'h400; d_rd = 1; d_addr = 32'h500;
        push(0, 32'h500, 0); push(0, 32'h400, 0);
        step(); idle_in();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            errors++; $display("FAIL arb_rr_d_first: req=%0b addr=%h want 1 00000500", mem_req, mem_addr);
        end
        repeat (12) step();
        i_xfer(32'h400, 3'd0, dat, ok);
        checks++;
        if (!ok || dat !== pat(32'h400)) begin
            errors++; $display("FAIL arb_rr_i: ok=%0b data=%h want %h", ok, dat, pat(32'h400));
        end
        d_xfer(32'h500, 1, 0, 0, dat, ok);
        checks++;
        if (!ok || dat !== pat(32'h500)) begin
            errors++; $display("FAIL arb_rr_d: ok=%0b data=%h want %h", ok, dat, pat(32'h500));
        end
    endtask

    task automatic test_segfault();
        logic [31:0] dat;
        bit ok;
        logic [31:0] bad [3];
        bad[0] = 32'h2; bad[1] = MW * 4; bad[2] = 32'hFFFF_FFFC;
        for (int k = 0; k < 3; k++) begin
            step(); d_rd = 1; d_addr = bad[k]; i_rd = 1; i_addr = 32'h41;
            @(negedge clk);
            checks++;
            if (d_segfault !== 1'b1 || d_miss !== 1'b0 || i_segfault !== 1'b1 || i_miss !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL segf_%0d: ds=%0b dm=%0b is=%0b im=%0b req=%0b want 1 0 1 0 0",
                         k, d_segfault, d_miss, i_segfault, i_miss, mem_req);
            end
        end
        step(); idle_in();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL segf_noreq: req=%0b want 0", mem_req);
        end
        push(0, MW * 4 - 4, 0);
        d_xfer(MW * 4 - 4, 1, 0, 0, dat, ok);
        checks++;
        if (!ok || dat !== pat(MW * 4 - 4)) begin
            errors++; $display("FAIL segf_top_word: ok=%0b data=%h want %h", ok, dat, pat(MW * 4 - 4));
        end
    endtask

    task automatic test_write_inval();
        logic [31:0] dat;
        bit ok;
        step(); i_rd = 1; i_addr = 32'h40; i_trd = 3'd2; push(0, 32'h40, 0);
        step(); idle_in();
        repeat (8) step();
        push(1, 32'h40, 32'h5);
        d_xfer(32'h40, 0, 1, 32'h5, dat, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_done: write never completed"); end
        step(); i_rd = 1; i_addr = 32'h40; i_trd = 3'd2; push(0, 32'h40, 0);
        @(negedge clk);
        checks++;
        if (i_miss !== 1'b1) begin
            errors++; $display("FAIL wr_inval: i_miss=%0b want 1", i_miss);
        end
        i_xfer(32'h40, 3'd2, dat, ok);
        checks++;
        if (!ok || dat !== 32'h5) begin
            errors++; $display("FAIL wr_refetch: ok=%0b data=%h want 00000005", ok, dat);
        end
        push(1, 32'h180, 32'h77);
        d_xfer(32'h180, 1, 1, 32'h77, dat, ok);
        push(0, 32'h180, 0);
        d_xfer(32'h180, 1, 0, 0, dat, ok);
        checks++;
        if (!ok || dat !== 32'h77) begin
            errors++; $display("FAIL rdwr_as_write: ok=%0b data=%h want 00000077", ok, dat);
        end
    endtask

    task automatic test_busy_drop();
        logic [31:0] dat;
        bit ok;
        step(); i_rd = 1; i_addr = 32'hC0; i_trd = 3'd1; push(0, 32'hC0, 0);
        step(); i_addr = 32'h80; i_trd = 3'd4;
        @(negedge clk);
        checks++;
        if (i_miss !== 1'b1) begin errors++; $display("FAIL busy_miss: i_miss=%0b want 1", i_miss); end
        step(); idle_in();
        step(); step();
        step(); i_rd = 1; i_addr = 32'h80; i_trd = 3'd4; push(0, 32'h80, 0);
        @(negedge clk);
        checks++;
        if (i_miss !== 1'b1) begin errors++; $display("FAIL busy_retry: i_miss=%0b want 1", i_miss); end
        step(); idle_in();
        step(); step();
        step(); i_rd = 1; i_addr = 32'hC0; i_trd = 3'd1;
        @(negedge clk);
        checks++;
        if (i_miss !== 1'b0 || i_rd_data !== pat(32'hC0) || mem_ack !== 1'b1) begin
            errors++;
            $display("FAIL fill_vs_hit: im=%0b data=%h ack=%0b want 0 %h 1", i_miss, i_rd_data, mem_ack, pat(32'hC0));
        end
        step(); i_addr = 32'h80; i_trd = 3'd4;
        @(negedge clk);
        checks++;
        if (i_miss !== 1'b0 || i_rd_data !== pat(32'h80)) begin
            errors++; $display("FAIL fill_wins: im=%0b data=%h want 0 %h", i_miss, i_rd_data, pat(32'h80));
        end
        step(); idle_in();
        push(0, 32'hC0, 0);
        i_xfer(32'hC0, 3'd1, dat, ok);
        checks++;
        if (!ok || dat !== pat(32'hC0)) begin
            errors++; $display("FAIL busy_refill: ok=%0b data=%h want %h", ok, dat, pat(32'hC0));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dat;
        bit ok;
        step(); d_rd = 1; d_addr = 32'h600; push(0, 32'h600, 0);
        step(); idle_in();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin
            errors++; $display("FAIL rmid_busy: req=%0b addr=%h want 1 00000600", mem_req, mem_addr);
        end
        step(); rst = 1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: req=%0b want 0", mem_req); end
        step(); rst = 0;
        step(); stray_ack = 1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_stray: req=%0b want 0", mem_req); end
        step(); stray_ack = 0;
        step(); d_rd = 1; d_addr = 32'h600; push(0, 32'h600, 0);
        @(negedge clk);
        checks++;
        if (d_miss !== 1'b1) begin errors++; $display("FAIL rmid_nofill: d_miss=%0b want 1", d_miss); end
        step(); idle_in();
        d_xfer(32'h600, 1, 0, 0, dat, ok);
        checks++;
        if (!ok || dat !== pat(32'h600)) begin
            errors++; $display("FAIL rmid_refetch: ok=%0b data=%h want %h", ok, dat, pat(32'h600));
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_segfault();
        test_write_inval();
        test_busy_drop();
        test_reset_mid();
        repeat (10) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d expected accesses never seen, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
